// File: rtl/posit_decode_sequencer.sv
// posit_decode_sequencer: shares one posit field extractor between both operands of an FPU op.
// Ports: clk/rst (async active-high); in_valid/in_ready/in_a/in_b/in_unary/in_tag accept a pair;
// out_valid/out_ready/out_tag/out_unary present it with decoded fields a_*/b_* plus any_inf/any_zero.

// posit_extraction: combinational posit decode into sign, regime k, exponent and mantissa.
// Ports: p in; sign, k (signed RS+1), exp, mant (hidden one at MSB, fraction left-justified), inf, zero out.
module posit_extraction #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) (
    input  logic [N-1:0]  p,
    output logic          sign,
    output logic [RS:0]   k,
    output logic [ES-1:0] exp,
    output logic [N-1:0]  mant,
    output logic          inf,
    output logic          zero
);
    logic [N-1:0] absv;
    logic [N-2:0] x;
    logic [RS:0]  run;
    logic         found;
    logic [N-1:0] tail;
    logic [N-2:0] frac;
    logic         special;

    always_comb begin
        absv = p[N-1] ? -p : p;
        // flipping the bits after the regime's first bit turns the regime run into leading zeros
        x = absv[N-2:0] ^ {(N-1){absv[N-2]}};
        run = (RS+1)'(N - 1);
        found = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!found && x[i]) begin
                run = (RS+1)'(N - 2 - i);
                found = 1'b1;
            end
        end
        // drop sign, regime run and terminator so the exponent sits at the top
        tail = absv << (run + 2'd2);
        frac = (N-1)'({tail, {ES{1'b0}}} >> 1);
    end

    assign zero    = p == '0;
    assign inf     = p == {1'b1, {(N-1){1'b0}}};
    assign special = zero | inf;
    assign sign    = p[N-1];
    assign k       = special ? '0 : (absv[N-2] ? run - 1'b1 : -run);
    assign exp     = special ? '0 : tail[N-1 -: ES];
    assign mant    = special ? '0 : {1'b1, frac};
endmodule

module posit_decode_sequencer #(
    parameter int N     = 32,
    parameter int ES    = 2,
    parameter int RS    = $clog2(N),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_unary,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_unary,
    output logic             a_sign,
    output logic [RS:0]      a_k,
    output logic [ES-1:0]    a_exp,
    output logic [N-1:0]     a_mant,
    output logic             a_inf,
    output logic             a_zero,
    output logic             b_sign,
    output logic [RS:0]      b_k,
    output logic [ES-1:0]    b_exp,
    output logic [N-1:0]     b_mant,
    output logic             b_inf,
    output logic             b_zero,
    output logic             any_inf,
    output logic             any_zero
);
    typedef enum logic [1:0] {IDLE, DEC_A, DEC_B, HOLD} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     held_a, held_b;
    logic             held_unary;
    logic [TAG_W-1:0] held_tag;
    logic             accept;
    logic             e_sign, e_inf, e_zero;
    logic [RS:0]      e_k;
    logic [ES-1:0]    e_exp;
    logic [N-1:0]     e_mant;

    assign in_ready  = state == IDLE || (state == HOLD && out_ready);
    assign out_valid = state == HOLD;
    assign accept    = in_valid & in_ready;
    assign out_tag   = held_tag;
    assign out_unary = held_unary;

    posit_extraction #(.N(N), .ES(ES), .RS(RS)) u_ext (
        .p    (state == DEC_B ? held_b : held_a),
        .sign (e_sign),
        .k    (e_k),
        .exp  (e_exp),
        .mant (e_mant),
        .inf  (e_inf),
        .zero (e_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = DEC_A;
            DEC_A:   state_nxt = held_unary ? HOLD : DEC_B;
            DEC_B:   state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = in_valid ? DEC_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_a     <= '0;
            held_b     <= '0;
            held_unary <= 1'b0;
            held_tag   <= '0;
            a_sign     <= 1'b0;
            a_k        <= '0;
            a_exp      <= '0;
            a_mant     <= '0;
            a_inf      <= 1'b0;
            a_zero     <= 1'b0;
            b_sign     <= 1'b0;
            b_k        <= '0;
            b_exp      <= '0;
            b_mant     <= '0;
            b_inf      <= 1'b0;
            b_zero     <= 1'b0;
            any_inf    <= 1'b0;
            any_zero   <= 1'b0;
        end else begin
            if (accept) begin
                held_a     <= in_a;
                held_b     <= in_b;
                held_unary <= in_unary;
                held_tag   <= in_tag;
            end
            if (state == DEC_A) begin
                a_sign <= e_sign;
                a_k    <= e_k;
                a_exp  <= e_exp;
                a_mant <= e_mant;
                a_inf  <= e_inf;
                a_zero <= e_zero;
                if (held_unary) begin
                    b_sign <= 1'b0;
                    b_k    <= '0;
                    b_exp  <= '0;
                    b_mant <= '0;
                    b_inf  <= 1'b0;
                    b_zero <= 1'b0;
                end
                // keep the summary flags consistent with whatever b_* will hold next cycle
                any_inf  <= e_inf | (~held_unary & b_inf);
                any_zero <= e_zero | (~held_unary & b_zero);
            end
            if (state == DEC_B) begin
                b_sign   <= e_sign;
                b_k      <= e_k;
                b_exp    <= e_exp;
                b_mant   <= e_mant;
                b_inf    <= e_inf;
                b_zero   <= e_zero;
                any_inf  <= a_inf | e_inf;
                any_zero <= a_zero | e_zero;
            end
        end
    end
endmodule

// File: tb/tb_posit_decode_sequencer.sv
// tb_posit_decode_sequencer: directed and randomized checks of the sequencer against a posit decode model.
module tb_posit_decode_sequencer;
    localparam int N = 32, ES = 2, RS = 5, TAG_W = 4;

    logic             clk = 1'b0, rst = 1'b1;
    logic             in_valid = 1'b0, in_ready, in_unary = 1'b0;
    logic [N-1:0]     in_a = '0, in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid, out_ready = 1'b0, out_unary;
    logic [TAG_W-1:0] out_tag;
    logic             a_sign, b_sign, a_inf, b_inf, a_zero, b_zero, any_inf, any_zero;
    logic [RS:0]      a_k, b_k;
    logic [ES-1:0]    a_exp, b_exp;
    logic [N-1:0]     a_mant, b_mant;

    int checks = 0, errors = 0;

    typedef struct { logic sign; int k; int exp; logic [31:0] mant; logic inf; logic zero; } dec_t;
    typedef struct { dec_t a; dec_t b; logic unary; logic [3:0] tag; } exp_t;

    posit_decode_sequencer #(.N(N), .ES(ES), .RS(RS), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_unary(in_unary), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_unary(out_unary), .a_sign(a_sign), .a_k(a_k), .a_exp(a_exp),
        .a_mant(a_mant), .a_inf(a_inf), .a_zero(a_zero), .b_sign(b_sign), .b_k(b_k), .b_exp(b_exp),
        .b_mant(b_mant), .b_inf(b_inf), .b_zero(b_zero), .any_inf(any_inf), .any_zero(any_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // Posit decode from the number-format definition: magnitude, regime run, exponent bits, fraction.
    function automatic dec_t ref_decode(input logic [31:0] p);
        dec_t d;
        longint unsigned mag;
        int first, m, pos, fb;
        d = '{default: 0};
        d.sign = p[31];
        d.zero = p == 32'h0;
        d.inf  = p == 32'h8000_0000;
        if (d.zero || d.inf) return d;
        mag = p[31] ? 64'h1_0000_0000 - 64'(p) : 64'(p);
        first = int'((mag >> 30) & 1);
        m = 0;
        while (m < 31 && int'((mag >> (30 - m)) & 1) == first) m++;
        d.k = first ? m - 1 : -m;
        pos = 29 - m;
        for (int j = 0; j < ES; j++)
            d.exp = d.exp * 2 + ((pos - j >= 0) ? int'((mag >> (pos - j)) & 1) : 0);
        fb = pos - ES + 1;
        d.mant = 32'h8000_0000;
        if (fb > 0) d.mant = d.mant | 32'((mag & ((64'd1 << fb) - 1)) << (31 - fb));
        return d;
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic u, input logic [3:0] t);
        exp_t e;
        e.a = ref_decode(a);
        e.b = u ? '{default: 0} : ref_decode(b);
        e.unary = u;
        e.tag = t;
        return e;
    endfunction

    function automatic logic [31:0] rnd_posit();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'h1 << $urandom_range(0, 31);
            3: return ~(32'h1 << $urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_out(input exp_t e, input string p);
        chk({p, ".valid"}, 64'(out_valid), 64'd1);
        chk({p, ".tag"}, 64'({out_tag, out_unary}), 64'({e.tag, e.unary}));
        chk({p, ".a"}, 64'({a_sign, a_k, a_exp, a_mant, a_inf, a_zero}),
            64'({e.a.sign, 6'(e.a.k), 2'(e.a.exp), e.a.mant, e.a.inf, e.a.zero}));
        chk({p, ".b"}, 64'({b_sign, b_k, b_exp, b_mant, b_inf, b_zero}),
            64'({e.b.sign, 6'(e.b.k), 2'(e.b.exp), e.b.mant, e.b.inf, e.b.zero}));
        chk({p, ".any"}, 64'({any_inf, any_zero}), 64'({e.a.inf | e.b.inf, e.a.zero | e.b.zero}));
    endtask

    task automatic scramble();
        in_a = $urandom; in_b = $urandom; in_unary = 1'($urandom); in_tag = 4'($urandom);
    endtask

    // Presents a pair and returns just after the accepting edge; inputs are then scrambled.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic u, input logic [3:0] t);
        int w = 0;
        in_a = a; in_b = b; in_unary = u; in_tag = t; in_valid = 1'b1;
        #1;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("send_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    // Counts clock edges from the accepting edge (counted as 1) until out_valid is seen.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("after_handoff", 64'(out_valid), 64'd0);
    endtask

    task automatic do_pair(input logic [31:0] a, input logic [31:0] b, input logic u,
                           input logic [3:0] t, input string name, output exp_t e);
        int n;
        e = mk(a, b, u, t);
        send(a, b, u, t);
        wait_out(n);
        chk({name, ".lat"}, 64'(n), u ? 64'd2 : 64'd3);
        check_out(e, name);
    endtask

    // Drives npairs through the sequencer; rand_mode adds source gaps and random backpressure.
    task automatic run_stream(input int npairs, input bit rand_mode);
        exp_t q[$];
        exp_t cur;
        int sent = 0, got = 0, last = -1;
        logic [31:0] a, b;
        logic u;
        logic [3:0] t;
        bit in_hs, out_hs;
        for (int cyc = 0; cyc < npairs * 12 + 50 && got < npairs; cyc++) begin
            out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!in_valid && sent < npairs && (!rand_mode || $urandom_range(0, 1) == 1)) begin
                a = rnd_posit(); b = rnd_posit();
                u = rand_mode ? 1'($urandom) : 1'b0;
                t = 4'(sent);
                in_a = a; in_b = b; in_unary = u; in_tag = t; in_valid = 1'b1;
                cur = mk(a, b, u, t);
            end
            #1;
            out_hs = out_valid && out_ready;
            in_hs = in_valid && in_ready;
            if (out_hs) begin
                if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
                else begin
                    check_out(q.pop_front(), rand_mode ? "rnd" : "stream");
                    if (!rand_mode && last >= 0) chk("stream.gap", 64'(cyc - last), 64'd3);
                end
                last = cyc;
                got++;
            end
            if (in_hs) begin
                q.push_back(cur);
                sent++;
            end
            @(posedge clk); #1;
            if (in_hs) begin
                in_valid = 1'b0;
                scramble();
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk(rand_mode ? "rnd.count" : "stream.count", 64'(got), 64'(npairs));
    endtask

    initial begin
        exp_t e, e2;
        int n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out", 64'({out_valid, out_tag, out_unary, any_inf, any_zero}), 64'd0);
        chk("rst.fields", 64'({a_sign, a_k, a_exp, a_mant, a_inf, a_zero}) |
            64'({b_sign, b_k, b_exp, b_mant, b_inf, b_zero}), 64'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        do_pair(32'h4000_0000, 32'h4800_0000, 1'b0, 4'd3, "bin", e);
        chk("bin.fields", 64'({a_k, a_exp, b_k, b_exp, a_sign, b_sign, out_tag}),
            64'({6'd0, 2'd0, 6'd0, 2'd1, 1'b0, 1'b0, 4'd3}));
        handoff();

        do_pair(32'h7FFF_FFFF, 32'h1234_5678, 1'b1, 4'd9, "unary", e);
        chk("unary.fields", 64'({a_k, a_exp, out_unary}), 64'({6'd30, 2'd0, 1'b1}));
        chk("unary.b_zeroed", 64'({b_sign, b_k, b_exp, b_mant, b_inf, b_zero}), 64'd0);
        handoff();

        do_pair(32'h8000_0000, 32'h0000_0000, 1'b0, 4'd5, "special", e);
        chk("special.flags", 64'({a_inf, b_zero, any_inf, any_zero, a_zero, b_inf}), 64'b111100);
        handoff();

        // backpressure: a new pair waits while the old one is held
        do_pair(32'hC3A5_0F11, 32'h0000_1234, 1'b0, 4'd7, "bp_old", e);
        e2 = mk(32'h5A5A_5A5A, 32'hF000_0001, 1'b0, 4'd12);
        in_a = 32'h5A5A_5A5A; in_b = 32'hF000_0001; in_unary = 1'b0; in_tag = 4'd12; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            check_out(e, "bp_hold");
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        scramble();
        wait_out(n);
        chk("bp_new.lat", 64'(n), 64'd3);
        check_out(e2, "bp_new");
        handoff();

        run_stream(4, 1'b0);

        // reset while decoding operand B
        send(32'h2345_6789, 32'h6000_0000, 1'b0, 4'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst.valid", 64'(out_valid), 64'd0);
        chk("midrst.fields", 64'({a_sign, a_k, a_exp, a_mant, a_inf, a_zero, any_inf, any_zero}) |
            64'({b_sign, b_k, b_exp, b_mant, b_inf, b_zero, out_tag, out_unary}), 64'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("midrst.in_ready", 64'(in_ready), 64'd1);
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("midrst.no_stale", 64'(n), 64'd0);
        do_pair(32'h0FED_CBA9, 32'hBEEF_0001, 1'b0, 4'd11, "post_rst", e);
        handoff();

        run_stream(150, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
